// File: rtl/riscv_pkg.sv
// Shared constants, types and helpers for the single-cycle RV32I subset core.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  // Opcodes
  localparam logic [6:0] OpR    = 7'b0110011;
  localparam logic [6:0] OpIAlu = 7'b0010011;
  localparam logic [6:0] OpLoad = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal  = 7'b1101111;

  // funct3 codes
  localparam logic [2:0] F3AddSub = 3'b000;
  localparam logic [2:0] F3Sll    = 3'b001;
  localparam logic [2:0] F3Slt    = 3'b010;
  localparam logic [2:0] F3LwSw   = 3'b010;
  localparam logic [2:0] F3Srl    = 3'b101;
  localparam logic [2:0] F3Or     = 3'b110;
  localparam logic [2:0] F3And    = 3'b111;
  localparam logic [2:0] F3Beq    = 3'b000;

  // funct7 bit 5 selects sub over add in R-type
  localparam int unsigned F7SubBit = 30;

  localparam logic [XLEN-1:0] X1Preset = 32'd3;
  localparam logic [XLEN-1:0] X2Preset = 32'd7;
  localparam logic [XLEN-1:0] X3Preset = 32'd12;

  localparam logic [31:0] InstrNop = 32'h0000_0013;

  typedef enum logic [3:0] {
    AluAdd = 4'd0,
    AluSub = 4'd1,
    AluAnd = 4'd2,
    AluOr  = 4'd3,
    AluSlt = 4'd4,
    AluSll = 4'd5,
    AluSrl = 4'd6
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    ImmI = 2'd0,
    ImmS = 2'd1,
    ImmB = 2'd2,
    ImmJ = 2'd3
  } imm_fmt_e;

  // Sign-extended immediate for the given encoding format.
  function automatic logic [XLEN-1:0] imm_gen(logic [31:0] instr, imm_fmt_e fmt);
    logic [XLEN-1:0] imm;
    case (fmt)
      ImmI:    imm = {{20{instr[31]}}, instr[31:20]};
      ImmS:    imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      ImmB:    imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      ImmJ:    imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

  // Register value loaded on reset.
  function automatic logic [XLEN-1:0] rf_preset(int unsigned idx);
    case (idx)
      1:       return X1Preset;
      2:       return X2Preset;
      3:       return X3Preset;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/riscv_alu.sv
// Combinational 32-bit ALU with zero flag for branch compare.
module riscv_alu
  import riscv_pkg::*;
(
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  alu_ctrl_e       ctrl,
  output logic [XLEN-1:0] y,
  output logic            zero
);

  // Operation select; arithmetic wraps with no overflow trap.
  always_comb begin
    y = '0;
    case (ctrl)
      AluAdd:  y = a + b;
      AluSub:  y = a - b;
      AluAnd:  y = a & b;
      AluOr:   y = a | b;
      AluSlt:  y = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      AluSll:  y = a << b[4:0];
      AluSrl:  y = a >> b[4:0];
      default: y = '0;
    endcase
  end

  assign zero = (y == '0);

endmodule

// File: rtl/riscv_single_cycle_core.sv
// Single-cycle RV32I subset core: fetch, decode, execute and commit in one clock.
module riscv_single_cycle_core
  import riscv_pkg::*;
#(
  parameter int unsigned IMEM_WORDS = 64,
  parameter int unsigned DMEM_WORDS = 64,
  parameter string       IMEM_FILE  = ""
) (
  input logic CLK,
  input logic rst
);

  localparam int unsigned IAW = $clog2(IMEM_WORDS);
  localparam int unsigned DAW = $clog2(DMEM_WORDS);

  logic [31:0]     imem [IMEM_WORDS];
  logic [XLEN-1:0] dmem_q [DMEM_WORDS] = '{default: '0};
  logic [XLEN-1:0] rf_q [32];
  logic [XLEN-1:0] pc_q, pc_d;

  // ROM image: built-in demo program.
  initial begin
    for (int i = 0; i < IMEM_WORDS; i++) imem[i] = InstrNop;
    imem[0] = 32'h4011_81B3;  // sub  x3,x3,x1
    imem[1] = 32'h0031_2233;  // slt  x4,x2,x3
    imem[2] = 32'h0002_0663;  // beq  x4,x0,+12
    imem[3] = 32'h0011_02B3;  // add  x5,x2,x1
    imem[4] = 32'h0000_006F;  // jal  x0,0
    imem[5] = 32'hFFF0_0293;  // addi x5,x0,-1
    imem[6] = 32'h0000_006F;  // jal  x0,0
  end

  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [XLEN-1:0] rs1_val, rs2_val, imm, alu_b, alu_y, wdata, pc_plus4;
  logic        reg_write, mem_write, alu_src_imm, branch, jump, is_load;
  logic        zero;
  alu_ctrl_e   alu_ctrl;
  imm_fmt_e    imm_fmt;

  assign instr   = imem[pc_q[IAW+1:2]];
  assign opcode  = instr[6:0];
  assign rd      = instr[11:7];
  assign funct3  = instr[14:12];
  assign rs1     = instr[19:15];
  assign rs2     = instr[24:20];
  assign rs1_val = (rs1 == '0) ? '0 : rf_q[rs1];
  assign rs2_val = (rs2 == '0) ? '0 : rf_q[rs2];

  // Main decoder; anything unrecognised falls through as a no-write PC+4.
  always_comb begin
    reg_write   = 1'b0;
    mem_write   = 1'b0;
    alu_src_imm = 1'b0;
    branch      = 1'b0;
    jump        = 1'b0;
    is_load     = 1'b0;
    alu_ctrl    = AluAdd;
    imm_fmt     = ImmI;
    case (opcode)
      OpR: begin
        reg_write = 1'b1;
        case (funct3)
          F3AddSub: alu_ctrl = instr[F7SubBit] ? AluSub : AluAdd;
          F3And:    alu_ctrl = AluAnd;
          F3Or:     alu_ctrl = AluOr;
          F3Slt:    alu_ctrl = AluSlt;
          F3Sll:    alu_ctrl = AluSll;
          F3Srl:    alu_ctrl = AluSrl;
          default:  reg_write = 1'b0;
        endcase
      end
      OpIAlu: begin
        reg_write   = 1'b1;
        alu_src_imm = 1'b1;
        case (funct3)
          F3AddSub: alu_ctrl = AluAdd;
          F3And:    alu_ctrl = AluAnd;
          F3Or:     alu_ctrl = AluOr;
          F3Slt:    alu_ctrl = AluSlt;
          default:  reg_write = 1'b0;
        endcase
      end
      OpLoad: begin
        reg_write   = (funct3 == F3LwSw);
        is_load     = 1'b1;
        alu_src_imm = 1'b1;
      end
      OpStore: begin
        mem_write   = (funct3 == F3LwSw);
        alu_src_imm = 1'b1;
        imm_fmt     = ImmS;
      end
      OpBranch: begin
        branch   = (funct3 == F3Beq);
        alu_ctrl = AluSub;
        imm_fmt  = ImmB;
      end
      OpJal: begin
        reg_write = 1'b1;
        jump      = 1'b1;
        imm_fmt   = ImmJ;
      end
      default: ;
    endcase
  end

  assign imm   = imm_gen(instr, imm_fmt);
  assign alu_b = alu_src_imm ? imm : rs2_val;

  riscv_alu u_alu (
    .a    (rs1_val),
    .b    (alu_b),
    .ctrl (alu_ctrl),
    .y    (alu_y),
    .zero (zero)
  );

  // Writeback select and next PC.
  always_comb begin
    pc_plus4 = pc_q + 32'd4;
    if (jump)         wdata = pc_plus4;
    else if (is_load) wdata = dmem_q[alu_y[DAW+1:2]];
    else              wdata = alu_y;
    pc_d = (jump || (branch && zero)) ? pc_q + imm : pc_plus4;
  end

  // PC and register file; reset restores presets and overrides any commit.
  always_ff @(posedge CLK) begin
    if (rst) begin
      pc_q <= '0;
      for (int i = 0; i < 32; i++) rf_q[i] <= rf_preset(i);
    end else begin
      pc_q <= pc_d;
      if (reg_write && rd != '0) rf_q[rd] <= wdata;
    end
  end

  // Data RAM store port; contents survive reset.
  always_ff @(posedge CLK) begin
    if (!rst && mem_write) dmem_q[alu_y[DAW+1:2]] <= rs2_val;
  end

  logic unused_bits;
  assign unused_bits = ^{pc_q[1:0], pc_q[31:IAW+2], alu_y[1:0], alu_y[31:DAW+2]};

endmodule

// File: tb/tb_riscv_single_cycle_core.sv
// Self-checking bench: built-in program, patched programs, reset corners, ALU vector table.
module tb_riscv_single_cycle_core;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  riscv_single_cycle_core #(
    .IMEM_WORDS (64),
    .DMEM_WORDS (64),
    .IMEM_FILE  ("")
  ) dut (
    .CLK (clk),
    .rst (rst)
  );

  typedef struct {
    logic [31:0] instr;
    logic [4:0]  rd;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    int          idx;
    logic [4:0]  rd;
    logic [31:0] val;
    logic [31:0] pc;
  } sb_t;

  vec_t vecs [14];
  sb_t  sbq [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 64; i++) dut.imem[i] = 32'h0000_0013;
  endtask

  task automatic check_presets(input string tag);
    check({tag, " pc"}, dut.pc_q, 32'h0);
    check({tag, " x1"}, dut.rf_q[1], 32'd3);
    check({tag, " x2"}, dut.rf_q[2], 32'd7);
    check({tag, " x3"}, dut.rf_q[3], 32'd12);
    check({tag, " x4"}, dut.rf_q[4], 32'd0);
    check({tag, " x5"}, dut.rf_q[5], 32'd0);
    check({tag, " x6"}, dut.rf_q[6], 32'd0);
  endtask

  initial begin
    sb_t e;

    // Built-in program
    rst = 1'b1;
    step(2);
    check_presets("reset");
    check("reset ram[2]", dut.dmem_q[2], 32'h0);
    rst = 1'b0;
    step(1);
    check("sub x3", dut.rf_q[3], 32'd9);
    check("sub pc", dut.pc_q, 32'h4);
    step(1);
    check("slt x4", dut.rf_q[4], 32'd1);
    check("slt pc", dut.pc_q, 32'h8);
    step(1);
    check("beq not taken pc", dut.pc_q, 32'h0C);
    step(1);
    check("add x5", dut.rf_q[5], 32'd10);
    check("add pc", dut.pc_q, 32'h10);
    step(40);
    check("halt pc", dut.pc_q, 32'h10);
    check("halt x3", dut.rf_q[3], 32'd9);
    check("halt x4", dut.rf_q[4], 32'd1);
    check("halt x5", dut.rf_q[5], 32'd10);

    // Same program with x4 forced to 0 so beq is taken
    rst = 1'b1;
    dut.imem[1] = 32'h0000_0213;  // addi x4,x0,0
    step(2);
    check_presets("reset2");
    rst = 1'b0;
    step(2);
    check("addi x4", dut.rf_q[4], 32'd0);
    step(1);
    check("beq taken pc", dut.pc_q, 32'h14);
    step(1);
    check("addi x5 -1", dut.rf_q[5], 32'hFFFF_FFFF);
    check("L1 pc", dut.pc_q, 32'h18);
    step(3);
    check("halt2 pc", dut.pc_q, 32'h18);

    // sw / lw / jal / x0 program
    rst = 1'b1;
    clear_rom();
    dut.imem[0] = 32'h0020_2423;  // sw   x2,8(x0)
    dut.imem[1] = 32'h0080_2303;  // lw   x6,8(x0)
    dut.imem[2] = 32'h0080_00EF;  // jal  x1,+8
    dut.imem[3] = 32'h0010_0393;  // addi x7,x0,1 (skipped)
    dut.imem[4] = 32'h0010_8033;  // add  x0,x1,x1
    dut.imem[5] = 32'h0000_006F;  // jal  x0,0
    step(2);
    rst = 1'b0;
    step(1);
    check("sw ram[2]", dut.dmem_q[2], 32'd7);
    step(1);
    check("lw x6", dut.rf_q[6], 32'd7);
    step(1);
    check("jal x1", dut.rf_q[1], 32'h0C);
    check("jal pc", dut.pc_q, 32'h10);
    step(1);
    check("x0 stays 0", dut.rf_q[0], 32'h0);
    check("skipped x7", dut.rf_q[7], 32'h0);
    check("x0 pc", dut.pc_q, 32'h14);
    step(2);
    check("halt3 pc", dut.pc_q, 32'h14);
    // Mid-run reset; sw at PC 0 is fetched while rst is high and must not store
    dut.dmem_q[2] = 32'h55;
    rst = 1'b1;
    step(1);
    check_presets("midrun");
    step(1);
    check("no store in reset", dut.dmem_q[2], 32'h55);

    // ALU vector table
    vecs[0]  = '{32'h0031_7333, 5'd6,  32'd4};           // and  x6,x2,x3
    vecs[1]  = '{32'h0031_63B3, 5'd7,  32'd15};          // or   x7,x2,x3
    vecs[2]  = '{32'h0011_1433, 5'd8,  32'd56};          // sll  x8,x2,x1
    vecs[3]  = '{32'h0011_D4B3, 5'd9,  32'd1};           // srl  x9,x3,x1
    vecs[4]  = '{32'h0061_7513, 5'd10, 32'd6};           // andi x10,x2,6
    vecs[5]  = '{32'h0080_E593, 5'd11, 32'd11};          // ori  x11,x1,8
    vecs[6]  = '{32'hFFF1_2613, 5'd12, 32'd0};           // slti x12,x2,-1
    vecs[7]  = '{32'hFFB0_0693, 5'd13, 32'hFFFF_FFFB};   // addi x13,x0,-5
    vecs[8]  = '{32'h0016_A733, 5'd14, 32'd1};           // slt  x14,x13,x1
    vecs[9]  = '{32'hFFC6_A793, 5'd15, 32'd1};           // slti x15,x13,-4
    vecs[10] = '{32'hFFF0_0813, 5'd16, 32'hFFFF_FFFF};   // addi x16,x0,-1
    vecs[11] = '{32'h0018_08B3, 5'd17, 32'd2};           // add  x17,x16,x1 (wraps)
    vecs[12] = '{32'h0038_5933, 5'd18, 32'h000F_FFFF};   // srl  x18,x16,x3
    vecs[13] = '{32'h0000_0FFF, 5'd31, 32'd0};           // unknown opcode, rd=31
    clear_rom();
    for (int i = 0; i < 14; i++) dut.imem[i] = vecs[i].instr;
    dut.imem[14] = 32'h0000_006F;
    step(1);
    rst = 1'b0;
    for (int i = 0; i < 14; i++) begin
      sbq.push_back('{i, vecs[i].rd, vecs[i].exp, 32'((i + 1) * 4)});
      step(1);
      e = sbq.pop_front();
      check($sformatf("vec%0d rd", e.idx), dut.rf_q[e.rd], e.val);
      check($sformatf("vec%0d pc", e.idx), dut.pc_q, e.pc);
    end
    step(2);
    check("table halt pc", dut.pc_q, 32'h38);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
